// File: rtl/regfile_sb_if.sv
// regfile_sb_if -- bundle of the register-file read, write, PC and issue
// signals shared between a requester (master) and regfile_sb (slave).
//
// Parameters:
//   WIDTH  data / PC width in bits
//   NREGS  register count (power of two, >= 4); selects are log2(NREGS) bits
//
// Signals (direction as seen by the register file):
//   regr0s, regr1s        in   read-port selects
//   regr0, regr1          out  read data
//   regr0_busy/regr1_busy out  selected register has a pending write
//   we, regws, regw       in   write / writeback port
//   incr_pc               in   advance PC
//   issue_valid,issue_reg in   request to reserve a destination register
//   issue_ready           out  reservation accepted this cycle
//   pc                    out  current PC (register NREGS-1)
interface regfile_sb_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]    regr0s;
  logic [AW-1:0]    regr1s;
  logic [WIDTH-1:0] regr0;
  logic [WIDTH-1:0] regr1;
  logic             regr0_busy;
  logic             regr1_busy;
  logic             we;
  logic [AW-1:0]    regws;
  logic [WIDTH-1:0] regw;
  logic             incr_pc;
  logic             issue_valid;
  logic [AW-1:0]    issue_reg;
  logic             issue_ready;
  logic [WIDTH-1:0] pc;

  modport master (
    output regr0s, regr1s, we, regws, regw, incr_pc, issue_valid, issue_reg,
    input  regr0, regr1, regr0_busy, regr1_busy, issue_ready, pc
  );

  modport slave (
    input  regr0s, regr1s, we, regws, regw, incr_pc, issue_valid, issue_reg,
    output regr0, regr1, regr0_busy, regr1_busy, issue_ready, pc
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb -- register file with a per-register scoreboard (busy bits)
// and a built-in program counter in the top register.
//
// Registers R1..R(NREGS-1) are stored; R(NREGS-1) doubles as the PC.
// Index 0 always reads 0, is never busy and discards writes.
// All state changes on the FALLING edge of clk; reset_n is asynchronous
// and active-low and clears every register and busy bit.
//
// Ports:
//   clk      in  clock (state updates on negedge)
//   reset_n  in  asynchronous active-low reset
//   bus      regfile_sb_if.slave -- read ports, write port, incr_pc,
//            issue handshake, pc output
//
// Optional feature: define REGFILE_BYPASS_EN to forward the write data
// (and a cleared busy flag) to a read port that selects the register being
// written in the same cycle. Without it, reads show the stored value until
// the falling edge commits the write.
module regfile_sb #(
  parameter int WIDTH   = 16,
  parameter int NREGS   = 8,   // power of two, >= 4
  parameter int PC_STEP = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int PC_IDX = NREGS - 1;
  localparam logic [AW-1:0] ZERO_IDX = '0;

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             wr_en;
  logic             issue_fire;

  // Issue handshake: the requester raises issue_valid with issue_reg and
  // holds both stable until a falling edge where issue_ready is also high;
  // that edge is the transfer and marks the register busy. issue_ready
  // depends only on the current busy bit, never on issue_valid, and a cycle
  // with issue_ready low has no effect on state.
  assign bus.issue_ready = (bus.issue_reg == ZERO_IDX) ? 1'b1 : !busy[bus.issue_reg];

  assign wr_en      = bus.we && (bus.regws != ZERO_IDX);
  assign issue_fire = bus.issue_valid && bus.issue_ready && (bus.issue_reg != ZERO_IDX);

  // Writeback clears, issue sets; the set is applied last so a same-edge
  // clear and set on one register leaves it busy (new producer in flight).
  always_comb begin
    busy_nxt = busy;
    if (bus.we) begin
      busy_nxt[bus.regws] = 1'b0;
    end
    if (issue_fire) begin
      busy_nxt[bus.issue_reg] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // The explicit write is evaluated after the PC increment so that a write
  // to the PC at the same edge overrides the increment.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (bus.incr_pc) begin
        regs[PC_IDX] <= regs[PC_IDX] + WIDTH'(PC_STEP);
      end
      if (wr_en) begin
        regs[bus.regws] <= bus.regw;
      end
      busy <= busy_nxt;
    end
  end

  assign bus.pc = regs[PC_IDX];

  always_comb begin
    bus.regr0      = (bus.regr0s == ZERO_IDX) ? '0 : regs[bus.regr0s];
    bus.regr1      = (bus.regr1s == ZERO_IDX) ? '0 : regs[bus.regr1s];
    bus.regr0_busy = busy[bus.regr0s];
    bus.regr1_busy = busy[bus.regr1s];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (bus.regws == bus.regr0s)) begin
      bus.regr0      = bus.regw;
      bus.regr0_busy = 1'b0;
    end
    if (wr_en && (bus.regws == bus.regr1s)) begin
      bus.regr1      = bus.regw;
      bus.regr1_busy = 1'b0;
    end
`endif
  end
endmodule
